// File: rtl/toaster_heat_timer_pkg.sv
// -----------------------------------------------------------------------------
// toaster_pkg
// Shared definitions for the toaster heater timer: channel state encoding,
// load clamping limits and the seconds-to-BCD helper used by the display path.
// No ports (package).
// -----------------------------------------------------------------------------
package toaster_pkg;

    // Per-channel control state.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } heat_state_t;

    // Longest loadable time: 15 min 59 s, the largest value the 3-digit
    // {minutes, tens, ones} readout can show.
    localparam int unsigned MAX_TIME_S = 32'd959;
    // Duty cycle is a percentage.
    localparam int unsigned MAX_DC     = 32'd100;

    // Seconds -> {minutes, tens of seconds, ones of seconds}, one nibble each.
    function automatic logic [11:0] bcd_time(input logic [31:0] secs);
        logic [31:0] mins;
        logic [31:0] rem_s;
        logic [31:0] tens;
        logic [31:0] ones;
        mins  = secs / 32'd60;
        rem_s = secs % 32'd60;
        tens  = rem_s / 32'd10;
        ones  = rem_s % 32'd10;
        return {mins[3:0], tens[3:0], ones[3:0]};
    endfunction

endpackage

// File: rtl/toaster_heat_timer_if.sv
// -----------------------------------------------------------------------------
// toaster_heat_timer_if
// Control/status bundle between the keypad/control FSM (master) and the heater
// timer (slave).
//   start/stop/load  [NCH]    per-channel requests (master -> slave)
//   load_time        [TIME_W] seconds to load, shared by all channels
//   load_dc          [DC_W]   duty cycle percent to load, shared
//   disp_sel         [SEL_W]  channel shown on disp
//   load_ack/done    [NCH]    one-cycle pulses (slave -> master)
//   busy/pwm         [NCH]    channel active / heater drive
//   disp             [12]     BCD {minutes, tens, ones}
// -----------------------------------------------------------------------------
interface toaster_heat_timer_if #(
    parameter int unsigned NCH    = 2,
    parameter int unsigned TIME_W = 10,
    parameter int unsigned DC_W   = 8
);
    localparam int unsigned SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]    start;
    logic [NCH-1:0]    stop;
    logic [NCH-1:0]    load;
    logic [TIME_W-1:0] load_time;
    logic [DC_W-1:0]   load_dc;
    logic [NCH-1:0]    load_ack;
    logic [NCH-1:0]    done;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    pwm;
    logic [SEL_W-1:0]  disp_sel;
    logic [11:0]       disp;

    modport master (
        output start, stop, load, load_time, load_dc, disp_sel,
        input  load_ack, done, busy, pwm, disp
    );

    modport slave (
        input  start, stop, load, load_time, load_dc, disp_sel,
        output load_ack, done, busy, pwm, disp
    );

endinterface

// File: rtl/toaster_heat_timer_chan.sv
// -----------------------------------------------------------------------------
// toaster_heat_chan
// One heater channel: IDLE/RUN/PAUSED/DONE control, one-second prescaler,
// seconds countdown and registered PWM (period = one second).
// Ports:
//   clk, reset              clock, async active-high reset
//   start_i/stop_i/load_i   requests; priority stop > load > start
//   load_time_i, load_dc_i  values captured on an accepted load (clamped)
//   load_ack_o, done_o      registered one-cycle pulses
//   busy_o                  state is RUN or PAUSED
//   pwm_o                   registered heater drive
//   remaining_o             seconds left, for the display path
// -----------------------------------------------------------------------------
module toaster_heat_chan
    import toaster_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 2000,
    parameter int unsigned TIME_W        = 10,
    parameter int unsigned DC_W          = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              load_i,
    input  logic [TIME_W-1:0] load_time_i,
    input  logic [DC_W-1:0]   load_dc_i,
    output logic              load_ack_o,
    output logic              done_o,
    output logic              busy_o,
    output logic              pwm_o,
    output logic [TIME_W-1:0] remaining_o
);

    localparam int unsigned CTR_W         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(TICKS_PER_SEC - 1);
    // PWM cycles per percent of duty.
    localparam int unsigned TICKS_PER_PCT = TICKS_PER_SEC / 32'd100;

    heat_state_t       state_q, state_d;
    logic [TIME_W-1:0] remaining_q, remaining_d;
    logic [DC_W-1:0]   dc_q, dc_d;
    logic [CTR_W-1:0]  ctr_q, ctr_d;
    logic              load_ack_q, load_ack_d;
    logic              done_q, done_d;
    logic              pwm_q, pwm_d;
    logic [TIME_W-1:0] time_clamp_s;
    logic [DC_W-1:0]   dc_clamp_s;

    assign time_clamp_s = (32'(load_time_i) > MAX_TIME_S) ? TIME_W'(MAX_TIME_S) : load_time_i;
    assign dc_clamp_s   = (32'(load_dc_i) > MAX_DC) ? DC_W'(MAX_DC) : load_dc_i;

    // Next-state, prescaler, countdown and pulse decode.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        dc_d        = dc_q;
        ctr_d       = ctr_q;
        load_ack_d  = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (stop_i) begin
                    // Clears DONE; a stop in IDLE also lands here and changes nothing.
                    state_d = IDLE;
                end else if (load_i) begin
                    state_d     = IDLE;
                    remaining_d = time_clamp_s;
                    dc_d        = dc_clamp_s;
                    load_ack_d  = 1'b1;
                end else if (start_i && (state_q == IDLE) && (remaining_q != '0)) begin
                    state_d = RUN;
                    ctr_d   = '0;
                end else begin
                    state_d = state_q;
                end
            end
            RUN: begin
                if (stop_i) begin
                    // Pause: everything holds, including this cycle's count.
                    state_d = PAUSED;
                end else if (ctr_q == CTR_LAST) begin
                    ctr_d       = '0;
                    remaining_d = remaining_q - TIME_W'(1);
                    if (remaining_q == TIME_W'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    ctr_d = ctr_q + CTR_W'(1);
                end
            end
            PAUSED: begin
                if (stop_i) begin
                    // Second stop aborts the cook.
                    state_d     = IDLE;
                    remaining_d = '0;
                end else if (start_i) begin
                    // Resume mid-second: prescaler keeps its position.
                    state_d = RUN;
                end else begin
                    state_d = PAUSED;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // PWM decision from the current cycle; registered below.
    always_comb begin
        if (state_q == RUN) begin
            pwm_d = (32'(ctr_q) < (32'(dc_q) * TICKS_PER_PCT));
        end else begin
            pwm_d = 1'b0;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            dc_q        <= '0;
            ctr_q       <= '0;
            load_ack_q  <= 1'b0;
            done_q      <= 1'b0;
            pwm_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            dc_q        <= dc_d;
            ctr_q       <= ctr_d;
            load_ack_q  <= load_ack_d;
            done_q      <= done_d;
            pwm_q       <= pwm_d;
        end
    end

    assign load_ack_o  = load_ack_q;
    assign done_o      = done_q;
    assign pwm_o       = pwm_q;
    assign busy_o      = (state_q == RUN) || (state_q == PAUSED);
    assign remaining_o = remaining_q;

endmodule

// File: rtl/toaster_heat_timer.sv
// -----------------------------------------------------------------------------
// toaster_heat_timer
// NCH independent heater channels (countdown + PWM) plus an optional BCD
// readout of the selected channel's remaining time.
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    toaster_heat_timer_if.slave: requests, load values, acks, done,
//          busy, pwm, disp_sel/disp
// Build option: TOASTER_BCD_DISP_EN -- when defined, disp shows the selected
// channel as BCD {minutes, tens, ones} with one cycle of latency; when not
// defined, disp is tied to 0 and no divide/modulo logic exists.
// -----------------------------------------------------------------------------
module toaster_heat_timer
    import toaster_pkg::*;
#(
    parameter int unsigned NCH           = 2,
    parameter int unsigned TICKS_PER_SEC = 2000,
    parameter int unsigned TIME_W        = 10,
    parameter int unsigned DC_W          = 8
) (
    input logic                 clk,
    input logic                 reset,
    toaster_heat_timer_if.slave bus
);

    logic [NCH-1:0]             load_ack_s;
    logic [NCH-1:0]             done_s;
    logic [NCH-1:0]             busy_s;
    logic [NCH-1:0]             pwm_s;
    logic [NCH-1:0][TIME_W-1:0] rem_s;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        toaster_heat_chan #(
            .TICKS_PER_SEC (TICKS_PER_SEC),
            .TIME_W        (TIME_W),
            .DC_W          (DC_W)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .start_i     (bus.start[g]),
            .stop_i      (bus.stop[g]),
            .load_i      (bus.load[g]),
            .load_time_i (bus.load_time),
            .load_dc_i   (bus.load_dc),
            .load_ack_o  (load_ack_s[g]),
            .done_o      (done_s[g]),
            .busy_o      (busy_s[g]),
            .pwm_o       (pwm_s[g]),
            .remaining_o (rem_s[g])
        );
    end

    assign bus.load_ack = load_ack_s;
    assign bus.done     = done_s;
    assign bus.busy     = busy_s;
    assign bus.pwm      = pwm_s;

`ifdef TOASTER_BCD_DISP_EN
    logic [TIME_W-1:0] sel_rem_s;
    logic              sel_ok_s;
    logic [11:0]       disp_d;
    logic [11:0]       disp_q;

    // AND-OR select of the displayed channel; out-of-range select shows 0.
    always_comb begin
        sel_rem_s = '0;
        sel_ok_s  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            sel_rem_s = sel_rem_s | (rem_s[i] & {TIME_W{32'(bus.disp_sel) == 32'(i)}});
            sel_ok_s  = sel_ok_s | (32'(bus.disp_sel) == 32'(i));
        end
        disp_d = sel_ok_s ? bcd_time(32'(sel_rem_s)) : 12'd0;
    end

    // Display register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_q <= 12'd0;
        end else begin
            disp_q <= disp_d;
        end
    end

    assign bus.disp = disp_q;
`else
    // Readout disabled: selector and remaining-time taps are intentionally unused.
    logic unused_disp_s;
    assign unused_disp_s = ^{bus.disp_sel, rem_s};
    assign bus.disp      = 12'd0;
`endif

endmodule

// File: tb/tb_toaster_heat_timer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for toaster_heat_timer (NCH=2, TICKS_PER_SEC=100).
// Expected values come from the behavioural rules: a load of N seconds finishes
// N*TPS cycles after start plus held cycles, each second carries
// min(dc,100)*TPS/100 PWM-high cycles, loads clamp to 959 s / 100 %.
// -----------------------------------------------------------------------------
module tb_toaster_heat_timer;

    localparam int NCH    = 2;
    localparam int TPS    = 100;
    localparam int TIME_W = 10;
    localparam int DC_W   = 8;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    toaster_heat_timer_if #(.NCH(NCH), .TIME_W(TIME_W), .DC_W(DC_W)) bus ();

    toaster_heat_timer #(
        .NCH(NCH), .TICKS_PER_SEC(TPS), .TIME_W(TIME_W), .DC_W(DC_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- reference rules ----------------
    function automatic int clamp_time(input int t);
        return (t > 959) ? 959 : t;
    endfunction

    function automatic int highs_per_sec(input int d);
        return ((d > 100) ? 100 : d) * TPS / 100;
    endfunction

    function automatic logic [11:0] exp_bcd(input int s);
        int m, tn, on;
        m  = s / 60;
        tn = (s % 60) / 10;
        on = s % 10;
        return {m[3:0], tn[3:0], on[3:0]};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start     = '0;
        bus.stop      = '0;
        bus.load      = '0;
        bus.load_time = '0;
        bus.load_dc   = '0;
        bus.disp_sel  = '0;
    endtask

    task automatic do_load(input int ch, input int t, input int d);
        logic [NCH-1:0] m;
        m = '0;
        m[ch] = 1'b1;
        bus.load_time = TIME_W'(t);
        bus.load_dc   = DC_W'(d);
        bus.load[ch]  = 1'b1;
        tick();
        bus.load[ch]  = 1'b0;
        total++;
        if (bus.load_ack !== m) begin
            bad++; $display("FAIL load_ack_pulse ch%0d: got %b expected %b", ch, bus.load_ack, m);
        end
        tick();
        total++;
        if (bus.load_ack !== '0) begin
            bad++; $display("FAIL load_ack_width ch%0d: got %b expected 00", ch, bus.load_ack);
        end
    endtask

    task automatic do_start(input int ch);
        bus.start[ch] = 1'b1;
        tick();
        bus.start[ch] = 1'b0;
    endtask

    task automatic do_stop(input int ch);
        bus.stop[ch] = 1'b1;
        tick();
        bus.stop[ch] = 1'b0;
    endtask

    // Called right after do_start: lat counts edges after the accepting edge.
    task automatic run_to_done(input int ch, input int budget,
                               output int lat, output int highs, output bit seen);
        lat = 0; highs = 0; seen = 1'b0;
        while (!seen && lat < budget) begin
            tick();
            lat++;
            if (bus.pwm[ch]) highs++;
            if (bus.done[ch]) seen = 1'b1;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        total++; if (bus.load_ack !== 2'b00) begin bad++; $display("FAIL reset_load_ack: got %b expected 00", bus.load_ack); end
        total++; if (bus.done !== 2'b00) begin bad++; $display("FAIL reset_done: got %b expected 00", bus.done); end
        total++; if (bus.busy !== 2'b00) begin bad++; $display("FAIL reset_busy: got %b expected 00", bus.busy); end
        total++; if (bus.pwm !== 2'b00) begin bad++; $display("FAIL reset_pwm: got %b expected 00", bus.pwm); end
        total++; if (bus.disp !== 12'h000) begin bad++; $display("FAIL reset_disp: got %h expected 000", bus.disp); end
        // Nothing loaded yet: start must be ignored.
        do_start(0);
        total++; if (bus.busy[0] !== 1'b0) begin bad++; $display("FAIL start_empty: got busy %b expected 0", bus.busy[0]); end
    endtask

    task automatic test_basic();
        int lat, highs; bit seen;
        do_load(0, 3, 50);
        do_start(0);
        total++; if (bus.busy[0] !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b expected 1", bus.busy[0]); end
        run_to_done(0, 400, lat, highs, seen);
        total++; if (!seen || lat != 3 * TPS) begin bad++; $display("FAIL basic_done_time: got %0d (seen %0d) expected %0d", lat, seen, 3 * TPS); end
        total++; if (highs != 3 * highs_per_sec(50)) begin bad++; $display("FAIL basic_pwm_highs: got %0d expected %0d", highs, 3 * highs_per_sec(50)); end
        tick();
        total++; if (bus.done[0] !== 1'b0 || bus.pwm[0] !== 1'b0 || bus.busy[0] !== 1'b0) begin
            bad++; $display("FAIL basic_after_done: got done %b pwm %b busy %b expected 0 0 0", bus.done[0], bus.pwm[0], bus.busy[0]);
        end
    endtask

    task automatic test_random_runs();
        int lat, highs; bit seen;
        for (int it = 0; it < 4; it++) begin
            int ch, t, d;
            ch = int'($urandom_range(0, NCH - 1));
            t  = int'($urandom_range(1, 2));
            d  = int'($urandom_range(0, 255));
            do_load(ch, t, d);
`ifdef TOASTER_BCD_DISP_EN
            bus.disp_sel = 1'(ch);
            tick();
            total++; if (bus.disp !== exp_bcd(clamp_time(t))) begin bad++; $display("FAIL rand_disp: got %h expected %h", bus.disp, exp_bcd(clamp_time(t))); end
`endif
            do_start(ch);
            run_to_done(ch, t * TPS + 50, lat, highs, seen);
            total++; if (!seen || lat != t * TPS) begin bad++; $display("FAIL rand_done_time ch%0d: got %0d expected %0d", ch, lat, t * TPS); end
            total++; if (highs != t * highs_per_sec(d)) begin bad++; $display("FAIL rand_pwm_highs dc%0d: got %0d expected %0d", d, highs, t * highs_per_sec(d)); end
            // Start in DONE is ignored.
            do_start(ch);
            tick();
            total++; if (bus.busy[ch] !== 1'b0) begin bad++; $display("FAIL start_in_done: got busy %b expected 0", bus.busy[ch]); end
        end
    endtask

    task automatic test_clamp();
        int lows;
        do_load(0, 1000, 150);
`ifdef TOASTER_BCD_DISP_EN
        bus.disp_sel = 1'b0;
        tick();
        total++; if (bus.disp !== 12'hF59) begin bad++; $display("FAIL clamp_disp: got %h expected F59", bus.disp); end
        bus.disp_sel = 1'b1;
        tick();
        total++; if (bus.disp === 12'hF59) begin bad++; $display("FAIL disp_select: got %h expected other channel", bus.disp); end
`endif
        do_start(0);
        lows = 0;
        repeat (200) begin
            tick();
            if (!bus.pwm[0]) lows++;
        end
        total++; if (lows != 0) begin bad++; $display("FAIL clamp_pwm_full: got %0d low cycles expected 0", lows); end
        do_stop(0);
        tick();
        total++; if (bus.pwm[0] !== 1'b0 || bus.busy[0] !== 1'b1) begin bad++; $display("FAIL clamp_pause: got pwm %b busy %b expected 0 1", bus.pwm[0], bus.busy[0]); end
        do_stop(0);
        total++; if (bus.busy[0] !== 1'b0) begin bad++; $display("FAIL clamp_abort: got busy %b expected 0", bus.busy[0]); end
`ifdef TOASTER_BCD_DISP_EN
        bus.disp_sel = 1'b0;
        tick();
        total++; if (bus.disp !== 12'h000) begin bad++; $display("FAIL abort_disp: got %h expected 000", bus.disp); end
`endif
    endtask

    task automatic test_pause();
        int e, lat, highs, err, d; bit seen;
        d = int'($urandom_range(1, 100));
        do_load(1, 2, d);
        do_start(1);
        e = cyc;
        repeat (149) tick();
        do_stop(1);                     // accepted at edge e+150
        err = 0;
        repeat (498) begin
            tick();
            if (bus.pwm[1] || !bus.busy[1]) err++;
        end
        total++; if (err != 0) begin bad++; $display("FAIL pause_hold: got %0d bad cycles expected 0", err); end
        // Resume at e+649: edges e+150..e+649 all hold the prescaler (500 edges).
        do_start(1);
        run_to_done(1, 300, lat, highs, seen);
        total++; if (!seen || cyc - e != 2 * TPS + 500) begin bad++; $display("FAIL pause_done_time: got %0d expected %0d", cyc - e, 2 * TPS + 500); end
        // Abort path.
        do_load(1, 2, d);
        do_start(1);
        repeat (50) tick();
        do_stop(1);
        do_stop(1);
        total++; if (bus.busy[1] !== 1'b0) begin bad++; $display("FAIL abort_idle: got busy %b expected 0", bus.busy[1]); end
        err = 0;
        repeat (300) begin
            tick();
            if (bus.done[1]) err++;
        end
        total++; if (err != 0) begin bad++; $display("FAIL abort_no_done: got %0d done pulses expected 0", err); end
        do_start(1);
        tick();
        total++; if (bus.busy[1] !== 1'b0) begin bad++; $display("FAIL abort_start_zero: got busy %b expected 0", bus.busy[1]); end
    endtask

    task automatic test_priority();
        int e, lat, highs, acks, err; bit seen;
        // Load during RUN is ignored.
        do_load(0, 1, 50);
        do_start(0);
        e = cyc;
        repeat (10) tick();
        bus.load_time = TIME_W'(5);
        bus.load[0]   = 1'b1;
        tick();
        bus.load[0]   = 1'b0;
        total++; if (bus.load_ack[0] !== 1'b0) begin bad++; $display("FAIL load_in_run_ack: got %b expected 0", bus.load_ack[0]); end
        run_to_done(0, 200, lat, highs, seen);
        total++; if (!seen || cyc - e != TPS) begin bad++; $display("FAIL load_in_run_time: got %0d expected %0d", cyc - e, TPS); end
        // Held load re-acks every cycle in IDLE/DONE.
        bus.load_time = TIME_W'(1);
        bus.load_dc   = DC_W'(50);
        bus.load[0]   = 1'b1;
        acks = 0;
        repeat (3) begin
            tick();
            if (bus.load_ack[0]) acks++;
        end
        bus.load[0] = 1'b0;
        total++; if (acks != 3) begin bad++; $display("FAIL held_load_acks: got %0d expected 3", acks); end
        // stop+start together in RUN pauses.
        do_start(0);
        repeat (5) tick();
        bus.start[0] = 1'b1;
        bus.stop[0]  = 1'b1;
        tick();
        bus.start[0] = 1'b0;
        bus.stop[0]  = 1'b0;
        err = 0;
        repeat (20) begin
            tick();
            if (bus.pwm[0] || !bus.busy[0]) err++;
        end
        total++; if (err != 0) begin bad++; $display("FAIL stop_start_pause: got %0d bad cycles expected 0", err); end
        do_stop(0);
        // load+start together in IDLE: load wins, stays IDLE.
        bus.load_time = TIME_W'(3);
        bus.load[0]   = 1'b1;
        bus.start[0]  = 1'b1;
        tick();
        bus.load[0]   = 1'b0;
        bus.start[0]  = 1'b0;
        total++; if (bus.load_ack[0] !== 1'b1 || bus.busy[0] !== 1'b0) begin bad++; $display("FAIL load_start: got ack %b busy %b expected 1 0", bus.load_ack[0], bus.busy[0]); end
        do_start(0);
        total++; if (bus.busy[0] !== 1'b1) begin bad++; $display("FAIL load_start_then_run: got busy %b expected 1", bus.busy[0]); end
        do_stop(0);
        do_stop(0);
    endtask

    task automatic test_independence();
        int e0, e1, t0, t1, gap, n;
        bus.load_time = TIME_W'(1);
        bus.load_dc   = DC_W'(10);
        bus.load      = 2'b11;
        tick();
        bus.load      = 2'b00;
        total++; if (bus.load_ack !== 2'b11) begin bad++; $display("FAIL dual_load_ack: got %b expected 11", bus.load_ack); end
        do_load(0, 2, int'($urandom_range(0, 100)));
        do_load(1, 1, int'($urandom_range(0, 100)));
        gap = int'($urandom_range(1, 40));
        do_start(0);
        e0 = cyc;
        repeat (gap - 1) tick();
        do_start(1);
        e1 = cyc;
        t0 = -1; t1 = -1; n = 0;
        while ((t0 < 0 || t1 < 0) && n < 400) begin
            tick();
            n++;
            if (bus.done[0]) t0 = cyc;
            if (bus.done[1]) t1 = cyc;
        end
        total++; if (t0 - e0 != 2 * TPS) begin bad++; $display("FAIL indep_ch0: got %0d expected %0d", t0 - e0, 2 * TPS); end
        total++; if (t1 - e1 != TPS) begin bad++; $display("FAIL indep_ch1: got %0d expected %0d", t1 - e1, TPS); end
    endtask

    task automatic test_reset_midrun();
        int err;
        do_load(0, 2, 100);
        do_load(1, 2, 100);
        bus.start = 2'b11;
        tick();
        bus.start = 2'b00;
        repeat (37) tick();
        total++; if (bus.pwm !== 2'b11) begin bad++; $display("FAIL pre_reset_pwm: got %b expected 11", bus.pwm); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (bus.pwm !== 2'b00 || bus.busy !== 2'b00 || bus.done !== 2'b00 || bus.load_ack !== 2'b00 || bus.disp !== 12'h000) begin
            bad++; $display("FAIL async_reset: got pwm %b busy %b done %b ack %b disp %h expected all 0", bus.pwm, bus.busy, bus.done, bus.load_ack, bus.disp);
        end
        tick();
        reset = 1'b0;
        err = 0;
        repeat (300) begin
            tick();
            if (bus.busy != 2'b00 || bus.done != 2'b00 || bus.pwm != 2'b00) err++;
        end
        total++; if (err != 0) begin bad++; $display("FAIL post_reset_idle: got %0d active cycles expected 0", err); end
        do_start(0);
        total++; if (bus.busy[0] !== 1'b0) begin bad++; $display("FAIL post_reset_start: got busy %b expected 0", bus.busy[0]); end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_basic();
        test_random_runs();
        test_clamp();
        test_pause();
        test_priority();
        test_independence();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
